icache_axi_refill: RTL and testbench
====================================

// Module: icache_axi_refill
// PURPOSE
//  Memory-side responder for the ICache line-refill interface. Accepts a line request,
//  issues one AXI4 INCR burst read and collects the beats into a line buffer.
//  Returns the whole line with a one-cycle grant. Sits between ICache and the AXI interconnect.
// PARAMETERS
//  OFFSET_LEN  5     line offset bits; WORDS = 1<<(OFFSET_LEN-2) 32-bit words per line (8)
//  ID_W        4     AXI ID width
//  AXI_ID      0     constant ARID driven on every burst
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  line_req     in   1            refill request; line_addr valid while high
//  line_addr    in   32           miss address; low OFFSET_LEN bits ignored
//  line_gnt     out  1            one-cycle pulse: line_data valid, refill complete
//  line_err     out  1            pulses with line_gnt if any beat had rresp!=OKAY or rlast misplaced
//  line_data    out  32 x WORDS   unpacked array [WORDS]; word i = line byte offset 4*i
//  arid/araddr  out  ID_W/32      AXI AR id / address
//  arlen/arsize out  8/3          WORDS-1 / 3'b010
//  arburst      out  2            2'b01 (INCR)
//  arvalid      out  1            AR valid
//  arready      in   1            AR ready
//  rid          in   ID_W         ignored (single outstanding burst)
//  rdata/rresp  in   32/2         R data / response
//  rlast/rvalid in   1/1          R last / valid
//  rready       out  1            R ready
// BEHAVIOUR
//  States: IDLE, ADDR, DATA, DONE; outputs decoded from registered state.
//  Reset: state=IDLE; arvalid=0, rready=0, line_gnt=0, line_err=0, line_data all 0, beat cnt=0.
//  IDLE: line_req=1 at edge -> latch {line_addr[31:OFFSET_LEN],OFFSET_LEN'b0} into araddr, cnt=0,
//    err=0; -> ADDR. line_req=0 -> stay.
//  ADDR: arvalid=1, araddr/arlen/arsize/arburst held stable; arready=1 -> DATA.
//  DATA: rready=1. On rvalid: line_data[cnt]<=rdata, cnt<=cnt+1 (3-bit, wraps at WORDS);
//    rresp!=2'b00 sets err. rvalid&rlast -> DONE; if cnt!=WORDS-1 at rlast, set err.
//    Beat at cnt==WORDS-1 without rlast: store, wrap cnt, set err, keep waiting for rlast.
//  DONE: line_gnt=1, line_err=err for exactly one cycle; -> IDLE unconditionally.
//  Minimum latency (arready, rvalid always 1): req sampled edge 0 -> arvalid cycle 1,
//    beats cycles 2..9, line_gnt cycle 10.
//  line_data held stable from line_gnt until the next accepted request's first beat.
//  Requester drops line_req the cycle after line_gnt; a line_req still high in IDLE
//    starts a new burst (no request filtering).
//  line_req dropped mid-burst: ignored; burst completes and line_gnt still pulses.
//  line_addr changes after acceptance: ignored (address latched in IDLE).
//  Reset mid-burst: immediate return to IDLE with all outputs at reset values; the system
//    reset also resets the AXI slave, so no drain of outstanding beats.
//  Exactly one outstanding AR at any time; arvalid never drops before arready.
// STRUCTURE
//  Shared package refill_pkg: refill_state_t enum {IDLE,ADDR,DATA,DONE}, AXI_BURST_INCR=2'b01,
//  AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00. Single module; no sub-module (line buffer is
//  a WORDS x 32 register array written by beat index).
// TESTING
//  1 arready=1, rvalid=1, data 0x100..0x107, req addr 0x1FC0_0034 -> araddr 0x1FC0_0020,
//    arlen=7, line_data[i]=0x100+i, line_gnt high cycle 10 only, line_err=0.
//  2 arready delayed 3 cycles, rvalid gap of 2 cycles after beats 2 and 5 -> araddr/arvalid
//    stable while waiting, same line_data, line_gnt at cycle 17, err=0.
//  3 beat 4 with rresp=2'b10 (SLVERR) -> full line still captured, line_gnt with line_err=1.
//  4 rlast on beat 6 (7 beats) -> DONE after beat 6, line_err=1; next burst starts with cnt=0.
//  5 rst asserted during beat 3 -> same cycle arvalid=rready=0, line_data=0, line_gnt never
//    pulses; new req after reset completes normally.
//  6 two requests back-to-back (line_req high 1 cycle after gnt) -> second AR issued,
//    first line_data held until second burst beat 0 arrives.

Source files
------------

// File: rtl/refill_pkg.sv
// Shared types and AXI encodings for the ICache line-refill responder.
// Also holds the per-beat error rule used when collecting R beats.
package refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // A beat is bad when it carries a non-OKAY response, or when rlast and the
  // last-word position disagree (early rlast, or a full line without rlast).
  function automatic logic beat_err(input logic [1:0] rresp,
                                    input logic       rlast,
                                    input logic       at_last_word);
    return (rresp != AXI_RESP_OKAY) || (rlast != at_last_word);
  endfunction

endpackage

// File: rtl/icache_axi_refill_checker.sv
// Protocol properties for icache_axi_refill: AR held until accepted, one-cycle grant,
// error only alongside grant, and no overlap of address and data phases.
module icache_axi_refill_checker (
  input logic        clk,
  input logic        rst,
  input logic        arvalid,
  input logic        arready,
  input logic [31:0] araddr,
  input logic        rready,
  input logic        line_gnt,
  input logic        line_err
);

  ap_ar_hold: assert property (@(posedge clk) disable iff (rst)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  ap_gnt_pulse: assert property (@(posedge clk) disable iff (rst)
    line_gnt |=> !line_gnt);

  ap_err_with_gnt: assert property (@(posedge clk) disable iff (rst)
    line_err |-> line_gnt);

  ap_phase_excl: assert property (@(posedge clk) disable iff (rst)
    !(arvalid && rready));

endmodule

// File: rtl/icache_axi_refill.sv
// ICache line-refill responder: one AXI4 INCR burst per line request, beats
// collected into a line buffer and returned with a one-cycle grant.
import refill_pkg::*;

module icache_axi_refill #(
  parameter int unsigned OFFSET_LEN = 5,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_req,
  input  logic [31:0]       line_addr,
  output logic              line_gnt,
  output logic              line_err,
  output logic [31:0]       line_data [1 << (OFFSET_LEN - 2)],
  output logic [ID_W-1:0]   arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned WORDS = 1 << (OFFSET_LEN - 2);
  localparam int unsigned CNT_W = OFFSET_LEN - 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  refill_state_t    state_q;
  logic [31:0]      araddr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             err_d;
  logic             arvalid_q;
  logic             rready_q;
  logic             gnt_q;
  logic             line_err_q;
  logic [31:0]      line_q [WORDS];

  // rid is unused with a single outstanding burst; low address bits select within the line.
  logic unused_ok;
  assign unused_ok = ^{rid, line_addr[OFFSET_LEN-1:0]};

  // Accumulated error including the beat currently on the R channel.
  always_comb begin
    err_d = err_q | beat_err(rresp, rlast, cnt_q == LAST_IDX);
  end

  // Refill FSM with registered AXI handshake and grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      araddr_q   <= 32'h0000_0000;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      gnt_q      <= 1'b0;
      line_err_q <= 1'b0;
      for (int i = 0; i < int'(WORDS); i++) begin
        line_q[i] <= 32'h0000_0000;
      end
    end else begin
      gnt_q      <= 1'b0;
      line_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (line_req) begin
            araddr_q  <= {line_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
            cnt_q     <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (rvalid && rready_q) begin
            line_q[cnt_q] <= rdata;
            cnt_q         <= cnt_q + CNT_W'(1);
            err_q         <= err_d;
            if (rlast) begin
              rready_q   <= 1'b0;
              gnt_q      <= 1'b1;
              line_err_q <= err_d;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign arid      = ID_W'(AXI_ID);
  assign araddr    = araddr_q;
  assign arlen     = 8'(WORDS - 1);
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign line_gnt  = gnt_q;
  assign line_err  = line_err_q;
  assign line_data = line_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Self-checking bench for icache_axi_refill: an AXI slave driver plus a line-level
// reference model (expected line, error flag and grant cycle from the burst shape).
module tb_icache_axi_refill;
  import refill_pkg::*;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_req;
  logic [31:0] line_addr;
  logic        line_gnt;
  logic        line_err;
  logic [31:0] line_data [WORDS];
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_line [WORDS];
  logic [31:0] bt_data [16];
  logic [1:0]  bt_resp [16];
  logic [15:0] gap_after;

  always #5 clk = ~clk;

  icache_axi_refill #(.OFFSET_LEN(5), .ID_W(4), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst), .line_req(line_req), .line_addr(line_addr),
    .line_gnt(line_gnt), .line_err(line_err), .line_data(line_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  icache_axi_refill_checker chk (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rready(rready), .line_gnt(line_gnt), .line_err(line_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1);
  end

  task automatic fill_beats(input bit seq_data);
    for (int k = 0; k < 16; k++) begin
      bt_data[k] = seq_data ? (32'h0000_0100 + 32'(k)) : $urandom;
      bt_resp[k] = 2'b00;
    end
    gap_after = 16'h0000;
  endtask

  // One refill: caller sits at a negedge. lead = idle cycles before the request is accepted.
  task automatic do_refill(input logic [31:0] addr, input int n_beats, input int ar_delay,
                           input bit keep_req, input int lead, input int rst_beat);
    int j = 0, arv_cycles = 0, ar_wait = 0, beat = 0, gap_left = 0;
    int gnt_cycle = -1, exp_gnt, total_gaps = 0;
    bit ar_done = 0, any_bad = 0, seen_gnt = 0, aborted = 0, line_bad;
    logic exp_err;
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFE0;
    for (int k = 0; k < n_beats; k++) begin
      if (bt_resp[k] != 2'b00) any_bad = 1;
      if (k < n_beats - 1 && gap_after[k]) total_gaps += 2;
    end
    exp_err = (n_beats != WORDS) || any_bad;
    exp_gnt = lead + 2 + ar_delay + n_beats + total_gaps;
    line_req  = 1'b1;
    line_addr = addr;
    while (!seen_gnt && !aborted && j < 300) begin
      @(negedge clk);
      j++;
      line_bad = 0;
      for (int i = 0; i < WORDS; i++) if (line_data[i] !== model_line[i]) line_bad = 1;
      n_checks++;
      if (line_bad) begin
        n_fail++;
        $display("FAIL line_data cycle %0d: got w0=%h w7=%h required w0=%h w7=%h",
                 j, line_data[0], line_data[7], model_line[0], model_line[7]);
      end
      if (line_gnt) begin
        seen_gnt  = 1;
        gnt_cycle = j;
        n_checks++;
        if (line_err !== exp_err) begin
          n_fail++;
          $display("FAIL line_err: got %b required %b", line_err, exp_err);
        end
      end
      if (arvalid) begin
        arv_cycles++;
        n_checks++;
        if (araddr !== exp_addr || arlen !== 8'd7 || arsize !== 3'b010 ||
            arburst !== 2'b01 || arid !== 4'd0) begin
          n_fail++;
          $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d id=%0d required addr=%h len=7 size=2 burst=1 id=0",
                   araddr, arlen, arsize, arburst, arid, exp_addr);
        end
      end
      if (j == lead + 1) begin
        line_addr = $urandom;
        if (!keep_req) line_req = 1'b0;
      end
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rdata   = $urandom;
      rresp   = 2'($urandom);
      rid     = 4'($urandom);
      if (arvalid && !ar_done) begin
        if (ar_wait < ar_delay) ar_wait++;
        else begin
          arready = 1'b1;
          ar_done = 1;
        end
      end else if (ar_done && beat < n_beats) begin
        if (gap_left > 0) gap_left--;
        else if (beat == rst_beat) begin
          rst = 1'b1;
          #1;
          line_bad = 0;
          for (int i = 0; i < WORDS; i++) if (line_data[i] !== 32'h0) line_bad = 1;
          n_checks++;
          if (arvalid !== 1'b0 || rready !== 1'b0 || line_gnt !== 1'b0 || line_bad) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got arvalid=%b rready=%b gnt=%b line_nonzero=%b required all 0",
                     arvalid, rready, line_gnt, line_bad);
          end
          for (int i = 0; i < WORDS; i++) model_line[i] = 32'h0;
          aborted = 1;
        end else begin
          rvalid = 1'b1;
          rdata  = bt_data[beat];
          rresp  = bt_resp[beat];
          rlast  = (beat == n_beats - 1);
          if (rready) begin
            model_line[beat % WORDS] = bt_data[beat];
            if (gap_after[beat]) gap_left = 2;
            beat++;
          end
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        n_checks++;
        if (line_gnt !== 1'b0 || arvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL post_reset_idle: got gnt=%b arvalid=%b required 0 0", line_gnt, arvalid);
        end
      end
    end else begin
      n_checks++;
      if (gnt_cycle != exp_gnt) begin
        n_fail++;
        $display("FAIL gnt_cycle: got %0d required %0d", gnt_cycle, exp_gnt);
      end
      n_checks++;
      if (arv_cycles != ar_delay + 1) begin
        n_fail++;
        $display("FAIL arvalid_cycles: got %0d required %0d", arv_cycles, ar_delay + 1);
      end
      if (!keep_req) begin
        line_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          n_checks++;
          if (line_gnt !== 1'b0 || arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_gnt: got gnt=%b arvalid=%b required 0 0", line_gnt, arvalid);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bit line_bad = 0;
    for (int i = 0; i < WORDS; i++) model_line[i] = 32'h0;
    rst = 1'b1; line_req = 1'b0; line_addr = 32'h0; arready = 1'b0;
    rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < WORDS; i++) if (line_data[i] !== 32'h0) line_bad = 1;
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || line_gnt !== 1'b0 || line_err !== 1'b0 || line_bad) begin
      n_fail++;
      $display("FAIL reset_state: got arvalid=%b rready=%b gnt=%b err=%b line_nonzero=%b required all 0",
               arvalid, rready, line_gnt, line_err, line_bad);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_min_latency();
    fill_beats(1);
    do_refill(32'h1FC0_0034, 8, 0, 0, 0, -1);
  endtask

  task automatic test_stalls();
    fill_beats(1);
    gap_after = 16'h0024;
    do_refill(32'h1FC0_0034, 8, 3, 0, 0, -1);
  endtask

  task automatic test_slverr();
    fill_beats(0);
    bt_resp[4] = 2'b10;
    do_refill($urandom, 8, 1, 0, 0, -1);
  endtask

  task automatic test_short_then_full();
    fill_beats(0);
    do_refill($urandom, 7, 0, 0, 0, -1);
    fill_beats(0);
    do_refill($urandom, 8, 0, 0, 0, -1);
  endtask

  task automatic test_missing_rlast();
    fill_beats(0);
    do_refill($urandom, 10, 0, 0, 0, -1);
  endtask

  task automatic test_reset_mid_burst();
    fill_beats(0);
    do_refill($urandom, 8, 0, 0, 0, 3);
    fill_beats(0);
    do_refill($urandom, 8, 2, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    fill_beats(0);
    do_refill($urandom, 8, 0, 1, 0, -1);
    fill_beats(0);
    do_refill($urandom, 8, 1, 0, 1, -1);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      fill_beats(0);
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 11)) : 8;
      gap_after = 16'($urandom) & 16'($urandom);
      for (int k = 0; k < 16; k++) if ($urandom_range(0, 7) == 0) bt_resp[k] = 2'($urandom_range(1, 3));
      do_refill($urandom, n, int'($urandom_range(0, 4)), 0, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_stalls();
    test_slverr();
    test_short_then_full();
    test_missing_rlast();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
